// File: rtl/alu_seq.sv
// alu_seq: registered ALU with single-cycle add/sub/logic/shift operations
// and a multi-cycle shift-and-add multiply. It uses a start/busy/done
// handshake, a gated result bus and a four-bit flags register.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             out,
  input  logic             flags_in,
  output logic [WIDTH-1:0] bus,
  output logic             busy,
  output logic             done,
  output logic             carry,
  output logic             zero,
  output logic             negative,
  output logic             overflow
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_MUL  = 1'b1;

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(WIDTH - 1);

  // Flags are packed as {carry, zero, negative, overflow}.
  logic [0:0]         state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [3:0]         candFlags_q, candFlags_d;
  logic [3:0]         flags_q, flags_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;

  logic [WIDTH-1:0]   bOperand;
  logic               carryIn;
  logic [WIDTH:0]     sumWide;
  logic [WIDTH-1:0]   aluResult;
  logic               aluCarry;
  logic               aluOvf;
  logic [3:0]         aluFlags;
  logic [2*WIDTH-1:0] accStep;
  logic [3:0]         mulFlags;

  // Single-cycle datapath; SUB reuses the adder as a + ~b + 1 so carry=1 means no borrow.
  always_comb begin
    bOperand  = b;
    carryIn   = 1'b0;
    if (op == OP_SUB) begin
      bOperand = ~b;
      carryIn  = 1'b1;
    end
    sumWide   = {1'b0, a} + {1'b0, bOperand} + {{WIDTH{1'b0}}, carryIn};
    aluResult = '0;
    aluCarry  = 1'b0;
    aluOvf    = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        aluResult = sumWide[WIDTH-1:0];
        aluCarry  = sumWide[WIDTH];
        aluOvf    = (a[WIDTH-1] == bOperand[WIDTH-1]) &&
                    (sumWide[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: aluResult = a & b;
      OP_OR:  aluResult = a | b;
      OP_XOR: aluResult = a ^ b;
      OP_SHL: begin
        aluResult = {a[WIDTH-2:0], 1'b0};
        aluCarry  = a[WIDTH-1];
      end
      OP_SHR: begin
        aluResult = {1'b0, a[WIDTH-1:1]};
        aluCarry  = a[0];
      end
      default: aluResult = '0;
    endcase
    aluFlags = {aluCarry, (aluResult == '0), aluResult[WIDTH-1], aluOvf};
  end

  // One shift-and-add step: add the shifted multiplicand when the current multiplier LSB is set.
  always_comb begin
    accStep  = acc_q + (mplier_q[0] ? mcand_q : '0);
    mulFlags = {(|accStep[2*WIDTH-1:WIDTH]), (accStep[WIDTH-1:0] == '0),
                accStep[WIDTH-1], 1'b0};
  end

  // Sequencer: IDLE completes simple ops immediately; MUL iterates WIDTH times then reports done.
  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    candFlags_d = candFlags_q;
    done_d      = 1'b0;
    count_d     = count_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (op == OP_MUL) begin
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            acc_d    = '0;
            count_d  = '0;
            state_d  = ST_MUL;
          end else begin
            result_d    = aluResult;
            candFlags_d = aluFlags;
            done_d      = 1'b1;
          end
        end
      end
      ST_MUL: begin
        acc_d    = accStep;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + CNT_W'(1);
        if (count_q == LAST_COUNT) begin
          result_d    = accStep[WIDTH-1:0];
          candFlags_d = mulFlags;
          done_d      = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    flags_d = flags_in ? candFlags_q : flags_q;
  end

  // State registers with synchronous reset; reset also aborts a multiply without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      result_q    <= '0;
      candFlags_q <= '0;
      flags_q     <= '0;
      done_q      <= 1'b0;
      count_q     <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      candFlags_q <= candFlags_d;
      flags_q     <= flags_d;
      done_q      <= done_d;
      count_q     <= count_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
    end
  end

  assign bus      = out ? result_q : '0;
  assign busy     = (state_q == ST_MUL);
  assign done     = done_q;
  assign carry    = flags_q[3];
  assign zero     = flags_q[2];
  assign negative = flags_q[1];
  assign overflow = flags_q[0];

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors for alu_seq at WIDTH=8 and WIDTH=16.
// Expected results are queued at issue time and popped by per-DUT monitors on done.
module tb_alu_seq;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef struct packed {
    logic [15:0] res;
    logic [3:0]  flg;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  logic        start8, out8, fin8;
  logic [2:0]  op8;
  logic [7:0]  a8, b8, bus8;
  logic        busy8, done8, carry8, zero8, neg8, ovf8;

  logic        start16, out16, fin16;
  logic [2:0]  op16;
  logic [15:0] a16, b16, bus16;
  logic        busy16, done16, carry16, zero16, neg16, ovf16;

  exp_t sb8[$];
  exp_t sb16[$];
  exp_t cur8, cur16;
  bit   pend8 = 1'b0;
  bit   pend16 = 1'b0;

  int checks = 0;
  int errors = 0;

  alu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .op(op8), .a(a8), .b(b8),
    .out(out8), .flags_in(fin8), .bus(bus8), .busy(busy8), .done(done8),
    .carry(carry8), .zero(zero8), .negative(neg8), .overflow(ovf8)
  );

  alu_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .op(op16), .a(a16), .b(b16),
    .out(out16), .flags_in(fin16), .bus(bus16), .busy(busy16), .done(done16),
    .carry(carry16), .zero(zero16), .negative(neg16), .overflow(ovf16)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  // Issues one operation; for single-cycle ops also checks done/busy one cycle later.
  task automatic applyStimulus(input bit wide, input bit syncNeg, input bit expectDone,
                               input logic [2:0] opV, input logic [15:0] aV,
                               input logic [15:0] bV, input logic [15:0] expRes,
                               input logic [3:0] expFlg);
    exp_t e;
    e.res = expRes;
    e.flg = expFlg;
    if (syncNeg) @(negedge clk);
    if (wide) begin
      start16 = 1'b1; op16 = opV; a16 = aV; b16 = bV;
      if (expectDone) sb16.push_back(e);
    end else begin
      start8 = 1'b1; op8 = opV; a8 = aV[7:0]; b8 = bV[7:0];
      if (expectDone) sb8.push_back(e);
    end
    @(negedge clk);
    start8  = 1'b0;
    start16 = 1'b0;
    if (opV != OP_MUL) begin
      checkOutput("doneLatency", 32'(wide ? done16 : done8), 32'd1);
      checkOutput("busyLow", 32'(wide ? busy16 : busy8), 32'd0);
    end
  endtask

  // Counts busy cycles until done (bounded); optionally pokes start mid-multiply.
  task automatic waitDone(input bit wide, input bit inject, output int busyCycles,
                          output bit seen);
    busyCycles = 0;
    seen = 1'b0;
    if (inject) begin
      op8 = OP_ADD; a8 = 8'h01; b8 = 8'h01;
    end
    for (int i = 0; i < 64; i++) begin
      if (wide ? done16 : done8) begin
        seen = 1'b1;
        break;
      end
      if (wide ? busy16 : busy8) busyCycles++;
      if (inject) start8 = (busyCycles == 3);
      @(negedge clk);
    end
    start8 = 1'b0;
  endtask

  // Monitor for the 8-bit DUT: result on done, flags one edge later if flags_in was set.
  initial forever begin
    @(posedge clk);
    #1;
    if (pend8) begin
      pend8 = 1'b0;
      if (fin8) checkOutput("flags8", 32'({carry8, zero8, neg8, ovf8}), 32'(cur8.flg));
    end
    if (done8) begin
      if (sb8.size() == 0) begin
        checkOutput("unexpectedDone8", 32'(done8), 32'd0);
      end else begin
        cur8 = sb8.pop_front();
        if (out8) checkOutput("bus8", 32'(bus8), 32'(cur8.res));
        pend8 = 1'b1;
      end
    end
  end

  // Monitor for the 16-bit DUT, same scheme.
  initial forever begin
    @(posedge clk);
    #1;
    if (pend16) begin
      pend16 = 1'b0;
      if (fin16) checkOutput("flags16", 32'({carry16, zero16, neg16, ovf16}), 32'(cur16.flg));
    end
    if (done16) begin
      if (sb16.size() == 0) begin
        checkOutput("unexpectedDone16", 32'(done16), 32'd0);
      end else begin
        cur16 = sb16.pop_front();
        if (out16) checkOutput("bus16", 32'(bus16), 32'(cur16.res));
        pend16 = 1'b1;
      end
    end
  end

  // Hard stop in case something hangs.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main directed sequence.
  initial begin
    int  bc;
    bit  seen;
    bit  sawDone;
    rst = 1'b1;
    start8 = 1'b0; op8 = '0; a8 = '0; b8 = '0; out8 = 1'b1; fin8 = 1'b1;
    start16 = 1'b0; op16 = '0; a16 = '0; b16 = '0; out16 = 1'b1; fin16 = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    checkOutput("resetBus8", 32'(bus8), 32'd0);
    checkOutput("resetBusy8", 32'(busy8), 32'd0);
    checkOutput("resetDone8", 32'(done8), 32'd0);
    checkOutput("resetFlags8", 32'({carry8, zero8, neg8, ovf8}), 32'd0);
    checkOutput("resetBus16", 32'(bus16), 32'd0);

    applyStimulus(1'b0, 1'b1, 1'b1, OP_ADD, 16'h00FF, 16'h0001, 16'h0000, 4'b1100);
    applyStimulus(1'b0, 1'b1, 1'b1, OP_SUB, 16'h0005, 16'h0007, 16'h00FE, 4'b0010);
    applyStimulus(1'b0, 1'b1, 1'b1, OP_ADD, 16'h007F, 16'h0001, 16'h0080, 4'b0011);
    applyStimulus(1'b0, 1'b1, 1'b1, OP_SUB, 16'h0080, 16'h0001, 16'h007F, 4'b1001);

    applyStimulus(1'b0, 1'b1, 1'b1, OP_MUL, 16'h000D, 16'h000B, 16'h008F, 4'b0010);
    waitDone(1'b0, 1'b1, bc, seen);
    checkOutput("mulDoneSeen", 32'(seen), 32'd1);
    checkOutput("mulBusyCycles", 32'(bc), 32'd8);
    checkOutput("mulBusyFallen", 32'(busy8), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, OP_ADD, 16'h0010, 16'h0020, 16'h0030, 4'b0000);

    applyStimulus(1'b0, 1'b1, 1'b1, OP_MUL, 16'h0020, 16'h0010, 16'h0000, 4'b1100);
    waitDone(1'b0, 1'b0, bc, seen);
    checkOutput("mulOvfDoneSeen", 32'(seen), 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b1, OP_SHL, 16'h0081, 16'h0000, 16'h0002, 4'b1000);
    applyStimulus(1'b0, 1'b1, 1'b1, OP_SHR, 16'h0001, 16'h0000, 16'h0000, 4'b1100);
    applyStimulus(1'b0, 1'b1, 1'b1, OP_XOR, 16'h00AA, 16'h00FF, 16'h0055, 4'b0000);
    applyStimulus(1'b0, 1'b1, 1'b1, OP_AND, 16'h00F0, 16'h003C, 16'h0030, 4'b0000);

    @(negedge clk);
    out8 = 1'b0;
    #1;
    checkOutput("busGated", 32'(bus8), 32'd0);
    out8 = 1'b1;
    #1;
    checkOutput("busDriven", 32'(bus8), 32'h30);

    @(negedge clk);
    fin8 = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b1, OP_OR, 16'h000F, 16'h0080, 16'h008F, 4'b0010);
    repeat (3) @(negedge clk);
    checkOutput("flagsHeld", 32'({carry8, zero8, neg8, ovf8}), 32'd0);
    fin8 = 1'b1;
    @(negedge clk);
    checkOutput("flagsLateLoad", 32'({carry8, zero8, neg8, ovf8}), 32'b0010);

    applyStimulus(1'b0, 1'b1, 1'b0, OP_MUL, 16'h0003, 16'h0003, 16'h0000, 4'b0000);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rstBusy", 32'(busy8), 32'd0);
    checkOutput("rstDone", 32'(done8), 32'd0);
    checkOutput("rstBus", 32'(bus8), 32'd0);
    checkOutput("rstFlags", 32'({carry8, zero8, neg8, ovf8}), 32'd0);
    sawDone = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done8) sawDone = 1'b1;
    end
    checkOutput("rstNoDone", 32'(sawDone), 32'd0);
    checkOutput("rstCandFlags", 32'({carry8, zero8, neg8, ovf8}), 32'd0);

    applyStimulus(1'b1, 1'b1, 1'b1, OP_MUL, 16'h0100, 16'h0100, 16'h0000, 4'b1100);
    waitDone(1'b1, 1'b0, bc, seen);
    checkOutput("mul16DoneSeen", 32'(seen), 32'd1);
    checkOutput("mul16BusyCycles", 32'(bc), 32'd16);
    applyStimulus(1'b1, 1'b1, 1'b1, OP_ADD, 16'hFFFF, 16'h0002, 16'h0001, 4'b1000);

    repeat (4) @(negedge clk);
    checkOutput("sb8Drained", 32'(sb8.size()), 32'd0);
    checkOutput("sb16Drained", 32'(sb16.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered successor to the CPU's 8-bit add/subtract ALU. It adds logic, shift and multi-cycle multiply operations, a start/busy/done handshake and a four-bit flags register. It sits between the A and B registers and the shared bus. The control sequencer starts an operation, waits for `done`, then asserts `out` to drive the result onto the bus and `flags_in` to capture flags.

## Interface
- `WIDTH`, default 8: data width of `a`, `b`, result and `bus`; must be ≥ 2.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst`  input  1  reset, synchronous, active-high.
- `start`  input  1  when idle, capture `a`, `b` and `op` and begin the operation.
- `op`  input  3  operation select:
  - 000 ADD, 001 SUB, 010 AND, 011 OR
  - 100 XOR, 101 SHL, 110 SHR, 111 MUL
- `a`, `b`  input  WIDTH  operands; sampled only on an accepted `start`.
- `out`  input  1  drive the result register onto `bus`.
- `flags_in`  input  1  load the flags register from the candidate flags.
- `bus`  output  WIDTH  equals the result register when `out` = 1, otherwise 0 (no tristate).
- `busy`  output  1  multiply in progress.
- `done`  output  1  one-cycle pulse: the result register is newly valid.
- `carry`, `zero`, `negative`, `overflow`  output  1 each  flags register outputs.

## Operation
- Two states: IDLE and MUL. Reset enters IDLE.
- **Reset values:** result 0, candidate flags 0, flags register 0, `busy` 0, `done` 0, multiply counter 0.
- **IDLE, `start` = 1, `op` ≠ MUL:** at that edge the result register and candidate flags load from the combinational computation. `done` = 1 next cycle. The block stays in IDLE.
- **IDLE, `start` = 1, `op` = MUL:** latch the operands, clear the accumulator, go to MUL.
  - Shift-and-add, one multiplier bit per cycle, LSB first, WIDTH iterations.
  - Internal product is 2·WIDTH bits.
  - On completion, result = low WIDTH bits; return to IDLE with a `done` pulse.
- **MUL state:** `start` is ignored and does not queue.
- **Arithmetic rules (WIDTH bits, modular):**
  - ADD: result = a+b. carry = carry-out. overflow = signed overflow.
  - SUB: computed as a + ~b + 1. carry = carry-out, so carry = 1 means no borrow (a ≥ b unsigned). overflow = signed overflow.
  - AND/OR/XOR: bitwise. carry = 0, overflow = 0.
  - SHL: result = a<<1. carry = a[WIDTH-1]. overflow = 0. `b` is unused.
  - SHR: logical, result = a>>1. carry = a[0]. overflow = 0.
  - MUL: unsigned. carry = 1 iff the high WIDTH product bits are nonzero. overflow = 0.
  - All operations: zero = (result == 0); negative = result[WIDTH-1].
- **Flags register:** loads candidate flags on any edge where `flags_in` = 1, including the `done` cycle. Candidate flags persist until the next operation completes, so a late `flags_in` still captures the last result's flags.
- `bus` and `flags_in` are independent of `busy`. During MUL, `bus` shows the previous result.
- **Reset mid-operation:** aborts the multiply. No `done` pulse; all values return to their reset values.

## Timing
- Let start be sampled at edge 0.
- **Single-cycle ops:**
  - Result and candidate flags are valid after edge 0.
  - `done` = 1 between edges 0 and 1.
  - `busy` stays 0.
- **MUL:**
  - `busy` = 1 after edges 0 … WIDTH−1 (WIDTH cycles).
  - The result updates at edge WIDTH.
  - `busy` falls and `done` = 1 for the cycle after edge WIDTH.
  - A new `start` in the `done` cycle is accepted (back-to-back issue).
- `bus` is combinational from `out` and the result register, with zero-cycle latency.
- Flags outputs change on the edge after `flags_in` is sampled.
- `start` and `rst` at the same edge: reset wins.

## Test plan
Use WIDTH = 8 unless noted.
- **ADD with carry:** ADD a=0xFF, b=0x01, then `flags_in` pulse.
  - Result 0x00; carry=1, zero=1, negative=0, overflow=0.
  - `done` one cycle after start; `busy` never high.
- **SUB and signed overflow:**
  - SUB a=5, b=7 → 0xFE, carry=0, negative=1.
  - ADD 0x7F+0x01 → 0x80, overflow=1, negative=1.
  - SUB 0x80−0x01 → 0x7F, overflow=1, carry=1.
- **MUL without overflow:** MUL 13×11.
  - `busy` high for exactly 8 cycles; `done` at cycle 9.
  - Result 0x8F, carry=0.
  - `start` pulses while busy are ignored; a back-to-back ADD in the `done` cycle completes next cycle.
- **MUL overflow, shifts, logic:**
  - MUL 0x20×0x10 → 0x00, carry=1, zero=1.
  - SHL 0x81 → 0x02, carry=1.
  - SHR 0x01 → 0x00, carry=1, zero=1.
  - XOR 0xAA^0xFF → 0x55.
- **Reset mid-multiply and bus gating:**
  - Assert `rst` on MUL cycle 4: `busy`=0, `done` never pulses, `bus`=0, all flags 0.
  - With `out`=0, `bus`=0 regardless of result.
  - Flags stay unchanged while `flags_in`=0.
- **WIDTH=16:**
  - MUL 0x0100×0x0100 → 0x0000, carry=1; `busy` for 16 cycles.
  - ADD 0xFFFF+0x0002 → 0x0001, carry=1.
